icache: RTL and testbench

Direct-mapped, read-only instruction cache between the pipelined MIPS core's fetch port and main memory. Serves `instr`/`ihit` combinationally on a hit. On a miss, refills one whole line from memory with a word-per-beat valid/ready handshake while holding `ihit` low, which stalls fetch.

---
 rtl/icache.sv | 101 ++++++++++
 tb/tb_icache.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache between fetch and main memory.
// Hits are served combinationally; a miss refills the whole line one word per beat.
module icache #(
    parameter int LINE_WORDS = 4,
    parameter int NUM_LINES  = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] pc_i,
    output logic [31:0] instr_o,
    output logic        hit_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ready_i
);

    localparam int OB = $clog2(LINE_WORDS);
    localparam int IB = $clog2(NUM_LINES);
    localparam int TB = 32 - OB - IB - 2;
    localparam logic [OB-1:0] LAST = OB'(LINE_WORDS - 1);

    typedef enum logic {
        IDLE,
        FILL
    } state_t;

    state_t               state;
    logic [OB-1:0]        beat_cnt;
    logic [TB-1:0]        miss_tag;
    logic [IB-1:0]        miss_idx;
    logic [NUM_LINES-1:0] valid;

    logic [TB-1:0] tag_arr  [NUM_LINES];
    logic [31:0]   data_arr [NUM_LINES][LINE_WORDS];

    logic [OB-1:0] pc_off;
    logic [IB-1:0] pc_idx;
    logic [TB-1:0] pc_tag;
    logic          beat_ok;
    logic          last_beat;
    logic          unused_pc;

    assign pc_off    = pc_i[OB+1:2];
    assign pc_idx    = pc_i[OB+IB+1:OB+2];
    assign pc_tag    = pc_i[31:OB+IB+2];
    assign unused_pc = ^pc_i[1:0];

    assign beat_ok   = (state == FILL) && mem_ready_i;
    assign last_beat = beat_ok && (beat_cnt == LAST);

    // Lookup is suppressed during a refill so fetch stays stalled.
    assign hit_o   = (state == IDLE) && valid[pc_idx] && (tag_arr[pc_idx] == pc_tag);
    assign instr_o = hit_o ? data_arr[pc_idx][pc_off] : 32'h0;

    assign mem_req_o  = (state == FILL);
    assign mem_addr_o = mem_req_o ? {miss_tag, miss_idx, beat_cnt, 2'b00} : 32'h0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            beat_cnt <= '0;
            miss_tag <= '0;
            miss_idx <= '0;
            valid    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!hit_o) begin
                        miss_tag       <= pc_tag;
                        miss_idx       <= pc_idx;
                        beat_cnt       <= '0;
                        valid[pc_idx]  <= 1'b0;
                        state          <= FILL;
                    end
                end
                FILL: begin
                    if (beat_ok) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                    if (last_beat) begin
                        valid[miss_idx] <= 1'b1;
                        state           <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag and data storage carry no reset; the valid bits guard them.
    always_ff @(posedge clk_i) begin
        if (beat_ok) begin
            data_arr[miss_idx][beat_cnt] <= mem_rdata_i;
        end
        if (last_beat) begin
            tag_arr[miss_idx] <= miss_tag;
        end
    end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: cold miss, hits, eviction, backpressure,
// reset during refill and fetch-address change during refill.
module tb_icache;

    logic        clk_i;
    logic        rst_i;
    logic [31:0] pc_i;
    logic [31:0] instr_o;
    logic        hit_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ready_i;

    int n_checks = 0;
    int n_fail   = 0;

    icache #(
        .LINE_WORDS(4),
        .NUM_LINES (16)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .pc_i       (pc_i),
        .instr_o    (instr_o),
        .hit_o      (hit_o),
        .mem_req_o  (mem_req_o),
        .mem_addr_o (mem_addr_o),
        .mem_rdata_i(mem_rdata_i),
        .mem_ready_i(mem_ready_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called just after a negedge with the line absent from the cache.
    task automatic do_miss(input string name, input logic [31:0] addr,
                           input logic [31:0] dbase, input logic [15:0] rpat,
                           input int plen);
        logic [31:0] a;
        logic [31:0] base;
        int beat;
        int lowcnt;
        a      = addr;
        base   = addr & 32'hFFFF_FFF0;
        beat   = 0;
        lowcnt = 0;
        pc_i        = addr;
        mem_ready_i = 1'b0;
        #1;
        check({name, " miss hit"}, 32'(hit_o), 32'd0);
        check({name, " miss req"}, 32'(mem_req_o), 32'd0);
        if (!hit_o) lowcnt++;
        for (int i = 0; i < plen; i++) begin
            @(negedge clk_i);
            mem_ready_i = rpat[i];
            mem_rdata_i = dbase + 32'(beat);
            #1;
            check({name, " fill req"}, 32'(mem_req_o), 32'd1);
            check({name, " fill addr"}, mem_addr_o, base + 32'(beat * 4));
            check({name, " fill hit"}, 32'(hit_o), 32'd0);
            if (!hit_o) lowcnt++;
            if (rpat[i]) beat++;
        end
        @(negedge clk_i);
        mem_ready_i = 1'b0;
        #1;
        check({name, " done hit"}, 32'(hit_o), 32'd1);
        check({name, " done instr"}, instr_o, dbase + 32'(a[3:2]));
        check({name, " done req"}, 32'(mem_req_o), 32'd0);
        check({name, " low cycles"}, 32'(lowcnt), 32'(plen + 1));
    endtask

    task automatic chk_hit(input string name, input logic [31:0] addr,
                           input logic [31:0] exp);
        @(negedge clk_i);
        pc_i        = addr;
        mem_ready_i = 1'b0;
        #1;
        check({name, " hit"}, 32'(hit_o), 32'd1);
        check({name, " instr"}, instr_o, exp);
        check({name, " req"}, 32'(mem_req_o), 32'd0);
    endtask

    initial begin
        rst_i       = 1'b1;
        pc_i        = 32'h40;
        mem_rdata_i = 32'h0;
        mem_ready_i = 1'b0;
        #1;
        check("rst hit", 32'(hit_o), 32'd0);
        check("rst instr", instr_o, 32'h0);
        check("rst req", 32'(mem_req_o), 32'd0);
        check("rst addr", mem_addr_o, 32'h0);

        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        do_miss("cold", 32'h40, 32'h1000, 16'h000F, 4);
        chk_hit("h44", 32'h44, 32'h1001);
        chk_hit("h4c", 32'h4C, 32'h1003);

        // Ready outside a refill must not disturb the array.
        @(negedge clk_i);
        pc_i        = 32'h48;
        mem_ready_i = 1'b1;
        mem_rdata_i = 32'hDEAD_BEEF;
        #1;
        check("idle rdy req", 32'(mem_req_o), 32'd0);
        check("idle rdy instr", instr_o, 32'h1002);
        chk_hit("idle rdy after", 32'h48, 32'h1002);

        @(negedge clk_i);
        do_miss("evict440", 32'h440, 32'h2000, 16'h000F, 4);
        @(negedge clk_i);
        do_miss("refill40", 32'h40, 32'h3000, 16'h000F, 4);
        chk_hit("h448 gone", 32'h40, 32'h3000);

        @(negedge clk_i);
        do_miss("bp", 32'h100, 32'h4000, 16'b1011001, 7);
        chk_hit("bp w1", 32'h104, 32'h4001);
        chk_hit("bp w2", 32'h108, 32'h4002);
        chk_hit("bp w3", 32'h10C, 32'h4003);

        // Reset after two beats of a refill.
        @(negedge clk_i);
        pc_i = 32'h200;
        #1;
        check("rm miss", 32'(hit_o), 32'd0);
        for (int b = 0; b < 2; b++) begin
            @(negedge clk_i);
            mem_ready_i = 1'b1;
            mem_rdata_i = 32'h5500 + 32'(b);
            #1;
            check("rm addr", mem_addr_o, 32'h200 + 32'(b * 4));
        end
        @(negedge clk_i);
        mem_ready_i = 1'b0;
        rst_i       = 1'b1;
        #1;
        check("rm req", 32'(mem_req_o), 32'd0);
        check("rm addr0", mem_addr_o, 32'h0);
        check("rm hit", 32'(hit_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        do_miss("rm refill", 32'h200, 32'h5000, 16'h000F, 4);
        chk_hit("rm w1", 32'h204, 32'h5001);

        // Fetch address moves to 0x80 after the first beat of the 0x40 refill.
        @(negedge clk_i);
        pc_i = 32'h40;
        #1;
        check("pcc miss", 32'(hit_o), 32'd0);
        for (int b = 0; b < 4; b++) begin
            @(negedge clk_i);
            if (b == 1) pc_i = 32'h80;
            mem_ready_i = 1'b1;
            mem_rdata_i = 32'h6000 + 32'(b);
            #1;
            check("pcc addr", mem_addr_o, 32'h40 + 32'(b * 4));
            check("pcc hit", 32'(hit_o), 32'd0);
        end
        @(negedge clk_i);
        do_miss("pcc 80", 32'h80, 32'h7000, 16'h000F, 4);
        chk_hit("pcc 40", 32'h40, 32'h6000);
        chk_hit("pcc 8c", 32'h8C, 32'h7003);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
